matrix_operand_loader: RTL and testbench

MATRIX_OPERAND_LOADER -- requirements
Module: matrix_operand_loader

---
 rtl/matrix_operand_loader.sv | 109 ++++++++++
 tb/tb_matrix_operand_loader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_operand_loader.sv
// Streams row-major elements of matrix A then matrix B into flattened registers and holds the
// assembled operand set plus op code for the matrix ALU. Optional macro: MATRIX_LOADER_ABORT_EN.
module matrix_operand_loader #(
  parameter int unsigned word_size     = 8,
  parameter int unsigned Amatrixrownum = 2,
  parameter int unsigned Amatrixcolnum = 2,
  parameter int unsigned Bmatrixrownum = 2,
  parameter int unsigned Bmatrixcolnum = 2
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [word_size-1:0]                             in_data,
  input  logic [1:0]                                       in_op,
`ifdef MATRIX_LOADER_ABORT_EN
  input  logic                                             abort,
`endif
  output logic [Amatrixrownum*Amatrixcolnum*word_size-1:0] A,
  output logic [Bmatrixrownum*Bmatrixcolnum*word_size-1:0] B,
  output logic [1:0]                                       op,
  output logic                                             out_valid,
  input  logic                                             out_ready
);

  localparam int unsigned NA   = Amatrixrownum * Amatrixcolnum;
  localparam int unsigned NB   = Bmatrixrownum * Bmatrixcolnum;
  localparam int unsigned MaxN = (NA > NB) ? NA : NB;
  localparam int unsigned CntW = (MaxN > 1) ? $clog2(MaxN) : 1;

  typedef enum logic [1:0] {
    StLoadA,
    StLoadB,
    StHold
  } state_e;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [NA*word_size-1:0] a_q;
  logic [NB*word_size-1:0] b_q;
  logic [1:0]              op_q;
  logic                    out_valid_q;

  // in_ready is a pure decode of the state register, so it is glitch-free and never depends on
  // same-cycle inputs.
  assign in_ready  = (state_q != StHold);
  assign A         = a_q;
  assign B         = b_q;
  assign op        = op_q;
  assign out_valid = out_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StLoadA;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 2'b00;
      out_valid_q <= 1'b0;
    end
`ifdef MATRIX_LOADER_ABORT_EN
    // Abort restarts the load but keeps whatever elements were already written.
    else if (abort && (state_q != StHold)) begin
      state_q <= StLoadA;
      cnt_q   <= '0;
    end
`endif
    else begin
      unique case (state_q)
        StLoadA: begin
          if (in_valid) begin
            a_q[cnt_q*word_size +: word_size] <= in_data;
            if (cnt_q == '0) op_q <= in_op;
            if (cnt_q == CntW'(NA - 1)) begin
              state_q <= StLoadB;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StLoadB: begin
          if (in_valid) begin
            b_q[cnt_q*word_size +: word_size] <= in_data;
            if (cnt_q == CntW'(NB - 1)) begin
              state_q     <= StHold;
              cnt_q       <= '0;
              out_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            state_q     <= StLoadA;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StLoadA;
          cnt_q       <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Randomised self-checking bench for matrix_operand_loader (default 2x2 x 2x2, 8-bit elements).
module tb_matrix_operand_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_op;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
`ifdef MATRIX_LOADER_ABORT_EN
  logic        abort;
`endif

  always #5 clk = ~clk;

  matrix_operand_loader dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_op    (in_op),
`ifdef MATRIX_LOADER_ABORT_EN
    .abort    (abort),
`endif
    .A        (a),
    .B        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int last_cycles;

  // Reference model: element k of the stream lands in A (k<4) or B (k>=4) at slot k mod 4.
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic [1:0]  exp_op;
  logic [7:0]  w [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_word(input int k, input logic [7:0] d, input logic [1:0] o);
    if (k < 4) exp_a[k*8 +: 8] = d;
    else       exp_b[(k-4)*8 +: 8] = d;
    if (k == 0) exp_op = o;
  endtask

  task automatic send_word(input logic [7:0] d, input logic [1:0] o, input bit rnd_or,
                           output int waited);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_op    = o;
    if (rnd_or) out_ready = 1'($urandom_range(0, 1));
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_word_ready got %b want 1 after %0d cycles", in_ready, guard);
    end
    waited = guard;
    step();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_op    = 2'($urandom);
  endtask

  // gap_mode: 0 none, 1 random idle cycles, 2 strict alternation of in_valid.
  task automatic load_range(input logic [1:0] o, input int first, input int last,
                            input int gap_mode, input bit rnd_or);
    int wt;
    logic [1:0] wop;
    last_cycles = 0;
    for (int k = first; k <= last; k++) begin
      if ((gap_mode == 1 && $urandom_range(0, 2) == 0) || (gap_mode == 2 && k > first)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (rnd_or) out_ready = 1'($urandom_range(0, 1));
        step();
        last_cycles++;
      end
      wop = (k == 0) ? o : 2'($urandom);
      send_word(w[k], wop, rnd_or, wt);
      last_cycles += wt + 1;
      model_word(k, w[k], wop);
    end
    out_ready = 1'b0;
  endtask

  task automatic check_done(input string name);
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out_valid got %b want 1", name, out_valid);
    end
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s in_ready got %b want 0", name, in_ready);
    end
    n_tests++;
    if (a !== exp_a) begin
      n_fail++;
      $display("FAIL %s A got %h want %h", name, a, exp_a);
    end
    n_tests++;
    if (b !== exp_b) begin
      n_fail++;
      $display("FAIL %s B got %h want %h", name, b, exp_b);
    end
    n_tests++;
    if (op !== exp_op) begin
      n_fail++;
      $display("FAIL %s op got %b want %b", name, op, exp_op);
    end
  endtask

  task automatic release_set(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release out_valid got %b want 0", name, out_valid);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release in_ready got %b want 1", name, in_ready);
    end
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if ({a, b, op, out_valid} !== '0) begin
      n_fail++;
      $display("FAIL %s A=%h B=%h op=%b out_valid=%b want all zero", name, a, b, op, out_valid);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready got %b want 1", name, in_ready);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    in_op     = 2'b11;
    out_ready = 1'b1;
`ifdef MATRIX_LOADER_ABORT_EN
    abort     = 1'b0;
`endif
    step();
    step();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_a = '0;
    exp_b = '0;
    exp_op = 2'b00;
    check_zero("reset");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) w[k] = 8'(k + 1);
    load_range(2'b10, 0, 7, 0, 1'b0);
    check_done("back_to_back");
    n_tests++;
    if (last_cycles != 8) begin
      n_fail++;
      $display("FAIL back_to_back cycles got %0d want 8", last_cycles);
    end
    n_tests++;
    if ({a, b, op} !== {32'h04030201, 32'h08070605, 2'b10}) begin
      n_fail++;
      $display("FAIL back_to_back literal A=%h B=%h op=%b want 04030201 08070605 10", a, b, op);
    end
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_op    = 2'($urandom);
      step();
      check_done($sformatf("hold_%0d", i));
    end
    in_valid = 1'b0;
    release_set("hold");
  endtask

  task automatic test_toggle();
    for (int k = 0; k < 8; k++) w[k] = 8'(8'hAA + k);
    load_range(2'b01, 0, 7, 2, 1'b0);
    check_done("toggle");
    n_tests++;
    if ({a, b} !== {32'hADACABAA, 32'hB1B0AFAE}) begin
      n_fail++;
      $display("FAIL toggle literal A=%h B=%h want ADACABAA B1B0AFAE", a, b);
    end
    release_set("toggle");
  endtask

  task automatic test_retention();
    int wt;
    w[0] = 8'h5A;
    send_word(w[0], 2'b11, 1'b0, wt);
    model_word(0, w[0], 2'b11);
    n_tests++;
    if ({a, b, op} !== {exp_a, exp_b, exp_op}) begin
      n_fail++;
      $display("FAIL retention got %h %h %b want %h %h %b", a, b, op, exp_a, exp_b, exp_op);
    end
    for (int k = 1; k < 8; k++) w[k] = 8'($urandom);
    load_range(2'b11, 1, 7, 0, 1'b0);
    check_done("retention");
    release_set("retention");
  endtask

  task automatic test_reset_midload();
    for (int k = 0; k < 8; k++) w[k] = 8'($urandom);
    load_range(2'b01, 0, 2, 0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_a = '0;
    exp_b = '0;
    exp_op = 2'b00;
    check_zero("reset_midload");
    for (int k = 0; k < 8; k++) w[k] = 8'(k + 9);
    load_range(2'b11, 0, 7, 0, 1'b0);
    check_done("reset_reload");
    n_tests++;
    if ({a, b} !== {32'h0C0B0A09, 32'h100F0E0D}) begin
      n_fail++;
      $display("FAIL reset_reload literal A=%h B=%h want 0C0B0A09 100F0E0D", a, b);
    end
    release_set("reset_reload");
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < 8; k++) w[k] = 8'($urandom);
      load_range(2'($urandom), 0, 7, 1, 1'b1);
      check_done($sformatf("random_%0d", it));
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        step();
      end
      in_valid = 1'b0;
      check_done($sformatf("random_hold_%0d", it));
      release_set($sformatf("random_%0d", it));
    end
  endtask

`ifdef MATRIX_LOADER_ABORT_EN
  task automatic test_abort();
    for (int k = 0; k < 8; k++) w[k] = 8'($urandom);
    load_range(2'b01, 0, 5, 0, 1'b0);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    n_tests++;
    if ({a, b, op, out_valid, in_ready} !== {exp_a, exp_b, exp_op, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_retain got %h %h %b %b %b want %h %h %b 0 1",
               a, b, op, out_valid, in_ready, exp_a, exp_b, exp_op);
    end
    for (int k = 0; k < 8; k++) w[k] = 8'(k + 1);
    load_range(2'b10, 0, 7, 0, 1'b0);
    check_done("abort_reload");
    n_tests++;
    if ({a, b} !== {32'h04030201, 32'h08070605}) begin
      n_fail++;
      $display("FAIL abort_reload literal A=%h B=%h want 04030201 08070605", a, b);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_done("abort_in_hold");
    release_set("abort");
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_hold();
    test_toggle();
    test_retention();
    test_reset_midload();
    test_random();
`ifdef MATRIX_LOADER_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
